// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry geometry, packed entry/tag types and the
// address-translation helper. The CP0 register block imports this package too.
package tlb_pkg;

    localparam int TLB_WIDTH = 4;
    localparam int ENTRY_W   = 86;

    localparam int C0_LSB    = 83;
    localparam int C1_LSB    = 80;
    localparam int ASID_LSB  = 72;
    localparam int G_BIT     = 71;
    localparam int VPN2_LSB  = 52;
    localparam int PFN1_LSB  = 28;
    localparam int PFN0_LSB  = 2;

    // Field widths are derived from the offsets so the struct and the
    // offsets cannot drift apart.
    typedef struct packed {
        logic [ENTRY_W-C0_LSB-1:0]        c0;
        logic [C0_LSB-C1_LSB-1:0]         c1;
        logic [C1_LSB-ASID_LSB-1:0]       asid;
        logic                             g;
        logic [G_BIT-VPN2_LSB-1:0]        vpn2;
        logic [VPN2_LSB-PFN1_LSB-1:0]     pfn1;
        logic                             d1;
        logic                             v1;
        logic [PFN1_LSB-2-PFN0_LSB-1:0]   pfn0;
        logic                             d0;
        logic                             v0;
    } tlb_entry_t;

    typedef struct packed {
        logic [7:0]  asid;
        logic        g;
        logic [18:0] vpn2;
    } tlb_tag_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        miss;
        logic        invalid;
        logic        modified;
        logic        cached;
    } xlate_t;

    function automatic xlate_t translate(input tlb_entry_t e, input logic hit,
                                         input logic [31:0] va, input logic store);
        xlate_t      r;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        r   = '0;
        pfn = va[12] ? e.pfn1[19:0] : e.pfn0[19:0];
        c   = va[12] ? e.c1 : e.c0;
        d   = va[12] ? e.d1 : e.d0;
        v   = va[12] ? e.v1 : e.v0;
        // kseg0/kseg1 bypass the TLB; kseg1 is the uncached window.
        if (va[31:30] == 2'b10) begin
            r.paddr  = {3'b000, va[28:0]};
            r.cached = ~va[29];
        end else begin
            r.paddr    = {pfn, va[11:0]};
            r.miss     = ~hit;
            r.invalid  = hit & ~v;
            r.modified = store & hit & v & ~d;
            r.cached   = hit & (c == 3'd3);
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative tag compare; the lowest matching index wins.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int W = TLB_WIDTH
) (
    input  tlb_tag_t [(1<<W)-1:0] tags_i,
    input  logic [(1<<W)-1:0]     present_i,
    input  logic [18:0]           vpn2_i,
    input  logic [7:0]            asid_i,
    output logic                  hit_o,
    output logic [W-1:0]          index_o
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        hit_o   = 1'b0;
        index_o = '0;
        for (int k = (1<<W) - 1; k >= 0; k--) begin
            if (present_i[k] && tags_i[k].vpn2 == vpn2_i &&
                (tags_i[k].g || tags_i[k].asid == asid_i)) begin
                hit_o   = 1'b1;
                index_o = W'(k);
            end
        end
    end

endmodule

// File: rtl/tlb.sv
// MIPS-style joint TLB: 2^TLB_WIDTH entries, registered instruction/data
// translation ports plus TLBP probe, TLBR read and TLBWI/TLBWR write.
module tlb #(
    parameter int TLB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [TLB_WIDTH-1:0] w_index,
    input  logic [85:0]          w_config,
    input  logic                 r_en,
    input  logic [TLB_WIDTH-1:0] r_index,
    output logic [85:0]          r_config,
    input  logic                 p_en,
    input  logic [31:0]          p_entryhi,
    output logic [31:0]          p_result,
    input  logic [7:0]           asid,
    input  logic                 i_req,
    input  logic [31:0]          i_vaddr,
    output logic                 i_valid,
    output logic [31:0]          i_paddr,
    output logic                 i_miss,
    output logic                 i_invalid,
    output logic                 i_cached,
    input  logic                 d_req,
    input  logic [31:0]          d_vaddr,
    input  logic                 d_store,
    output logic                 d_valid,
    output logic [31:0]          d_paddr,
    output logic                 d_miss,
    output logic                 d_invalid,
    output logic                 d_modified,
    output logic                 d_cached
);
    import tlb_pkg::*;

    localparam int N = 1 << TLB_WIDTH;

    tlb_entry_t [N-1:0]   entries_q;
    logic [N-1:0]         present_q;
    tlb_tag_t [N-1:0]     tags;
    logic                 i_hit, d_hit, p_hit;
    logic [TLB_WIDTH-1:0] i_idx, d_idx, p_idx;
    xlate_t               i_res_d, d_res_d, i_res_q, d_res_q;
    logic                 i_valid_q, d_valid_q;
    logic [85:0]          r_config_d, r_config_q;
    logic [31:0]          p_result_d, p_result_q;
    logic                 unused_bits;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            tags[k] = {entries_q[k].asid, entries_q[k].g, entries_q[k].vpn2};
        end
    end

    tlb_match #(.W(TLB_WIDTH)) u_imatch (
        .tags_i(tags), .present_i(present_q), .vpn2_i(i_vaddr[31:13]),
        .asid_i(asid), .hit_o(i_hit), .index_o(i_idx)
    );

    tlb_match #(.W(TLB_WIDTH)) u_dmatch (
        .tags_i(tags), .present_i(present_q), .vpn2_i(d_vaddr[31:13]),
        .asid_i(asid), .hit_o(d_hit), .index_o(d_idx)
    );

    // TLBP compares against the ASID carried in the probed EntryHi value.
    tlb_match #(.W(TLB_WIDTH)) u_pmatch (
        .tags_i(tags), .present_i(present_q), .vpn2_i(p_entryhi[31:13]),
        .asid_i(p_entryhi[7:0]), .hit_o(p_hit), .index_o(p_idx)
    );

    always_comb begin
        i_res_d    = translate(entries_q[i_idx], i_hit, i_vaddr, 1'b0);
        d_res_d    = translate(entries_q[d_idx], d_hit, d_vaddr, d_store);
        p_result_d = p_hit ? {{(32-TLB_WIDTH){1'b0}}, p_idx} : 32'h8000_0000;
        r_config_d = present_q[r_index] ? entries_q[r_index] : '0;
    end

    // All lookups above read the pre-write array, so a same-cycle write is
    // only visible from the following cycle onwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q <= '0;
            present_q <= '0;
        end else if (w_en) begin
            entries_q[w_index] <= w_config;
            present_q[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            i_res_q    <= '0;
            d_res_q    <= '0;
            p_result_q <= '0;
            r_config_q <= '0;
        end else begin
            i_valid_q <= i_req;
            d_valid_q <= d_req;
            if (i_req) i_res_q    <= i_res_d;
            if (d_req) d_res_q    <= d_res_d;
            if (p_en)  p_result_q <= p_result_d;
            if (r_en)  r_config_q <= r_config_d;
        end
    end

    assign i_valid    = i_valid_q;
    assign i_paddr    = i_res_q.paddr;
    assign i_miss     = i_res_q.miss;
    assign i_invalid  = i_res_q.invalid;
    assign i_cached   = i_res_q.cached;
    assign d_valid    = d_valid_q;
    assign d_paddr    = d_res_q.paddr;
    assign d_miss     = d_res_q.miss;
    assign d_invalid  = d_res_q.invalid;
    assign d_modified = d_res_q.modified;
    assign d_cached   = d_res_q.cached;
    assign p_result   = p_result_q;
    assign r_config   = r_config_q;

    assign unused_bits = ^{p_entryhi[12:8], i_res_q.modified};

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios followed by random traffic
// compared against an array-based model of the entry table.
module tb_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [3:0]  w_index;
    logic [85:0] w_config;
    logic        r_en;
    logic [3:0]  r_index;
    logic [85:0] r_config;
    logic        p_en;
    logic [31:0] p_entryhi, p_result;
    logic [7:0]  asid;
    logic        i_req, i_valid, i_miss, i_invalid, i_cached;
    logic [31:0] i_vaddr, i_paddr;
    logic        d_req, d_store, d_valid, d_miss, d_invalid, d_modified, d_cached;
    logic [31:0] d_vaddr, d_paddr;

    int nChecks = 0;
    int nFails  = 0;

    logic [85:0] mMem [16];
    logic        mPresent [16];

    logic [31:0] eIPa, eDPa, eP;
    logic        eIMiss, eIInv, eICac, eIKnown;
    logic        eDMiss, eDInv, eDMod, eDCac, eDKnown;
    logic [85:0] eR, entry3;

    tlb dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_index(w_index), .w_config(w_config),
        .r_en(r_en), .r_index(r_index), .r_config(r_config),
        .p_en(p_en), .p_entryhi(p_entryhi), .p_result(p_result),
        .asid(asid),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_valid(i_valid), .i_paddr(i_paddr),
        .i_miss(i_miss), .i_invalid(i_invalid), .i_cached(i_cached),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_valid(d_valid),
        .d_paddr(d_paddr), .d_miss(d_miss), .d_invalid(d_invalid),
        .d_modified(d_modified), .d_cached(d_cached)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [85:0] makeEntry(input logic [2:0] c0, input logic [2:0] c1,
            input logic [7:0] as, input logic g, input logic [18:0] vpn2,
            input logic [23:0] pfn1, input logic d1, input logic v1,
            input logic [23:0] pfn0, input logic d0, input logic v0);
        return {c0, c1, as, g, vpn2, pfn1, d1, v1, pfn0, d0, v0};
    endfunction

    function automatic int findIdx(input logic [18:0] vpn2, input logic [7:0] as);
        for (int k = 0; k < 16; k++) begin
            if (mPresent[k] && mMem[k][70:52] == vpn2 && (mMem[k][71] || mMem[k][79:72] == as))
                return k;
        end
        return -1;
    endfunction

    task automatic modelXlate(input logic [31:0] va, input logic [7:0] as, input logic store,
                              output logic [31:0] pa, output logic ms, output logic iv,
                              output logic md, output logic cc, output logic kn);
        int          idx;
        logic [85:0] e;
        logic [23:0] pfn;
        logic [2:0]  c;
        logic        v, d;
        pa = '0; ms = 0; iv = 0; md = 0; cc = 0; kn = 1;
        if (va[31:30] == 2'b10) begin
            pa = {3'b000, va[28:0]};
            cc = (va[29] == 1'b0);
        end else begin
            idx = findIdx(va[31:13], as);
            if (idx < 0) begin
                ms = 1;
                kn = 0;
            end else begin
                e   = mMem[idx];
                pfn = va[12] ? e[51:28] : e[25:2];
                v   = va[12] ? e[26] : e[0];
                d   = va[12] ? e[27] : e[1];
                c   = va[12] ? e[82:80] : e[85:83];
                pa  = {pfn[19:0], va[11:0]};
                iv  = !v;
                md  = store && v && !d;
                cc  = (c == 3'd3);
            end
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 16; k++) begin
            mMem[k]     = '0;
            mPresent[k] = 1'b0;
        end
        eIPa = '0; eIMiss = 0; eIInv = 0; eICac = 0; eIKnown = 1;
        eDPa = '0; eDMiss = 0; eDInv = 0; eDMod = 0; eDCac = 0; eDKnown = 1;
        eP = '0; eR = '0;
    endtask

    task automatic idle();
        w_en = 0; r_en = 0; p_en = 0; i_req = 0; d_req = 0; d_store = 0;
    endtask

    // One clock: predict from the pre-write model, advance, then commit the write.
    task automatic cycle();
        logic [31:0] pa;
        logic        ms, iv, md, cc, kn, expIv, expDv;
        int          pi;
        expIv = i_req;
        expDv = d_req;
        if (i_req) begin
            modelXlate(i_vaddr, asid, 1'b0, pa, ms, iv, md, cc, kn);
            eIPa = pa; eIMiss = ms; eIInv = iv; eICac = cc; eIKnown = kn;
        end
        if (d_req) begin
            modelXlate(d_vaddr, asid, d_store, pa, ms, iv, md, cc, kn);
            eDPa = pa; eDMiss = ms; eDInv = iv; eDMod = md; eDCac = cc; eDKnown = kn;
        end
        if (p_en) begin
            pi = findIdx(p_entryhi[31:13], p_entryhi[7:0]);
            eP = (pi < 0) ? 32'h8000_0000 : 32'(pi);
        end
        if (r_en) eR = mPresent[r_index] ? mMem[r_index] : '0;
        @(posedge clk);
        #1;
        if (w_en) begin
            mMem[w_index]     = w_config;
            mPresent[w_index] = 1'b1;
        end
        check("i_valid", i_valid, expIv);
        check("i_miss", i_miss, eIMiss);
        check("i_invalid", i_invalid, eIInv);
        if (eIKnown) begin
            check("i_paddr", i_paddr, eIPa);
            check("i_cached", i_cached, eICac);
        end
        check("d_valid", d_valid, expDv);
        check("d_miss", d_miss, eDMiss);
        check("d_invalid", d_invalid, eDInv);
        check("d_modified", d_modified, eDMod);
        if (eDKnown) begin
            check("d_paddr", d_paddr, eDPa);
            check("d_cached", d_cached, eDCac);
        end
        check("p_result", p_result, eP);
        check("r_config", r_config, eR);
    endtask

    task automatic writeEntry(input logic [3:0] idx, input logic [85:0] cfg);
        idle();
        w_en = 1; w_index = idx; w_config = cfg;
        cycle();
        w_en = 0;
    endtask

    function automatic logic [18:0] pickVpn();
        case ($urandom_range(0, 3))
            0:       return 19'h00200;
            1:       return 19'h00300;
            2:       return 19'h60001;
            default: return 19'h00201;
        endcase
    endfunction

    function automatic logic [31:0] randVaddr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            4:       return {3'b100, r[28:0]};
            5:       return {3'b101, r[28:0]};
            default: return {pickVpn(), r[12:0]};
        endcase
    endfunction

    function automatic logic [85:0] randEntry();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        r[70:52] = pickVpn();
        r[79:72] = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06;
        r[71]    = ($urandom_range(0, 3) == 0);
        return r[85:0];
    endfunction

    initial begin
        rst = 0;
        idle();
        asid = 8'h05; w_index = '0; w_config = '0; r_index = '0;
        p_entryhi = '0; i_vaddr = '0; d_vaddr = '0;
        clearModel();

        // Reset values
        cycle();
        cycle();
        #1 rst = 1;

        // First mapped fetch after reset misses
        i_req = 1; i_vaddr = 32'h0040_0000;
        cycle();
        check("first_fetch_miss", i_miss, 1'b1);

        // Write index 3 and translate a store through it
        entry3 = makeEntry(3'd3, 3'd0, 8'h05, 1'b0, 19'h00200, 24'h0, 1'b0, 1'b0,
                           24'h01234, 1'b0, 1'b1);
        writeEntry(4'd3, entry3);
        idle();
        d_req = 1; d_vaddr = 32'h0040_0abc; d_store = 1;
        cycle();
        check("store_paddr", d_paddr, 32'h0123_4abc);
        check("store_modified", d_modified, 1'b1);
        check("store_cached", d_cached, 1'b1);

        // ASID mismatch, then the same entry made global
        asid = 8'h06;
        cycle();
        check("asid_mismatch_miss", d_miss, 1'b1);
        entry3[71] = 1'b1;
        writeEntry(4'd3, entry3);
        d_req = 1; d_store = 0;
        cycle();
        check("global_hit", d_miss, 1'b0);
        check("global_paddr", d_paddr, 32'h0123_4abc);
        asid = 8'h05;

        // Unmapped segments
        idle();
        i_req = 1; i_vaddr = 32'hA000_1000;
        cycle();
        check("kseg1_paddr", i_paddr, 32'h0000_1000);
        check("kseg1_cached", i_cached, 1'b0);
        i_vaddr = 32'h8000_1000;
        cycle();
        check("kseg0_cached", i_cached, 1'b1);
        check("kseg0_miss", i_miss, 1'b0);

        // Probe hit/miss and read back
        idle();
        p_en = 1; p_entryhi = 32'h0040_0005;
        cycle();
        check("probe_hit", p_result, 32'h0000_0003);
        p_entryhi = 32'h1234_6005;
        cycle();
        check("probe_miss", p_result, 32'h8000_0000);
        idle();
        r_en = 1; r_index = 4'd3;
        cycle();
        check("read_entry3", r_config, {42'b0, entry3});

        // Collision: lookup and read alongside the write see old contents
        idle();
        w_en = 1; w_index = 4'd7;
        w_config = makeEntry(3'd2, 3'd3, 8'h05, 1'b0, 19'h00300, 24'h0, 1'b0, 1'b0,
                             24'h00777, 1'b1, 1'b1);
        d_req = 1; d_vaddr = 32'h0060_0010;
        r_en = 1; r_index = 4'd7;
        cycle();
        check("collision_miss", d_miss, 1'b1);
        check("collision_read", r_config, 86'b0);
        w_en = 0;
        cycle();
        check("after_write_hit", d_paddr, 32'h0077_7010);

        // Duplicate VPN2 at a lower index takes priority
        writeEntry(4'd2, makeEntry(3'd3, 3'd3, 8'h05, 1'b1, 19'h00300, 24'h0, 1'b0, 1'b0,
                                   24'h00abc, 1'b0, 1'b1));
        d_req = 1; p_en = 1; p_entryhi = 32'h0060_0005;
        cycle();
        check("lowest_index", p_result, 32'h0000_0002);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            asid = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06;
            w_en = ($urandom_range(0, 3) == 0);
            w_index = 4'($urandom_range(0, 15));
            w_config = randEntry();
            r_en = ($urandom_range(0, 1) == 0);
            r_index = 4'($urandom_range(0, 15));
            p_en = ($urandom_range(0, 1) == 0);
            p_entryhi = {pickVpn(), 5'b0, (($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06)};
            i_req = ($urandom_range(0, 1) == 0);
            i_vaddr = randVaddr();
            d_req = ($urandom_range(0, 1) == 0);
            d_vaddr = randVaddr();
            d_store = ($urandom_range(0, 1) == 0);
            cycle();
        end

        // Reset mid-operation with requests pending
        idle();
        i_req = 1; i_vaddr = 32'h0040_0abc; d_req = 1; d_vaddr = 32'h8000_0040;
        #2 rst = 0;
        #1;
        check("async_rst_i_valid", i_valid, 1'b0);
        check("async_rst_d_valid", d_valid, 1'b0);
        check("async_rst_r_config", r_config, 86'b0);
        check("async_rst_p_result", p_result, 32'b0);
        @(posedge clk);
        #1;
        idle();
        rst = 1;
        clearModel();
        cycle();
        i_req = 1; i_vaddr = 32'h0040_0abc;
        cycle();
        check("post_reset_miss", i_miss, 1'b1);
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter TLB_WIDTH, default 4, meaning log2 of the entry count (16 entries).
REQ-002 SHALL have ports clk, input, 1, rising-edge clock; and rst, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have write port: w_en input 1 (TLBWI/TLBWR strobe); w_index input TLB_WIDTH; w_config input 86 (entry to store).
REQ-004 SHALL have read port: r_en input 1 (TLBR); r_index input TLB_WIDTH; r_config output 86 (entry read).
REQ-005 SHALL have probe port: p_en input 1 (TLBP); p_entryhi input 32 (VPN2 in [31:13], ASID in [7:0]); p_result output 32 (Index-register format).
REQ-006 SHALL have asid input 8 (current EntryHi ASID), used by both translation ports.
REQ-007 SHALL have instruction port:
- inputs: i_req 1; i_vaddr 32.
- outputs: i_valid 1; i_paddr 32; i_miss 1; i_invalid 1; i_cached 1.
REQ-008 SHALL have data port:
- inputs: d_req 1; d_vaddr 32; d_store 1.
- outputs: d_valid 1; d_paddr 32; d_miss 1; d_invalid 1; d_modified 1; d_cached 1.

Function
REQ-009 SHALL use this 86-bit entry layout:
- C0 85:83; C1 82:80; ASID 79:72; G 71; VPN2 70:52.
- PFN1 51:28; D1,V1 27:26; PFN0 25:2; D0,V0 1:0.
REQ-010 SHALL keep a per-entry present bit: 0 at reset, set on write; an entry that is not present never matches.
REQ-011 SHALL match an entry when present, VPN2 == vaddr[31:13], and (G==1 or entry ASID == asid).
REQ-012 SHALL resolve multiple matches to the lowest index.
REQ-013 SHALL select the page by vaddr[12]: 0 uses PFN0/C0/D0/V0, 1 uses PFN1/C1/D1/V1.
REQ-014 SHALL map kuseg (va[31]==0) and kseg2/3 (va[31:30]==11) through the TLB, with paddr = {PFN[19:0], va[11:0]}.
REQ-015 SHALL bypass the TLB for kseg0 (va[31:29]==100): paddr = {3'b000, va[28:0]}, cached=1, no miss/invalid/modified.
REQ-016 SHALL bypass the TLB for kseg1 (va[31:29]==101): paddr as kseg0, cached=0, no miss/invalid/modified.
REQ-017 SHALL compute translation flags as:
- miss = mapped and no match.
- invalid = mapped, match, selected V==0.
- modified = d_store, mapped, match, V==1, D==0.
- cached = (selected C == 3).
REQ-018 SHALL register each translation port with latency 1: a request at edge N gives *_valid=1 with its results after edge N; *_valid=0 otherwise.
REQ-019 SHALL hold *_paddr and flags at their last values when *_valid=0.
REQ-020 SHALL drive paddr as don't-care when miss=1; the bench SHALL NOT check it.
REQ-021 SHALL perform the write at the clock edge when w_en=1.
REQ-022 SHALL have lookups, probe and read in the same cycle as a write see the pre-write contents.
REQ-023 SHALL give probe latency 1:
- hit: p_result = {1'b0, 27'b0, index}.
- miss: p_result = 32'h80000000.
- p_result holds its value when p_en=0.
REQ-024 SHALL give read latency 1: r_config = stored entry, or all zeros if that entry is not present; r_config holds when r_en=0.
REQ-025 SHALL let i_req, d_req, p_en, r_en and w_en all be asserted in one cycle with independent results.

Reset
REQ-026 SHALL, on asserted reset:
- clear all present bits and entry storage;
- set i_valid=d_valid=0;
- set all paddr, flags, r_config and p_result to 0.
REQ-027 SHALL, on reset asserted mid-operation, drop any pending result (no *_valid pulse after release).
REQ-028 SHALL make the first translation after release of a mapped address report miss.

Structure
REQ-029 SHALL place TLB_WIDTH, the entry field offsets and a packed entry struct typedef in shared package tlb_pkg, also used by the CP0 register block.
REQ-030 SHALL implement matching in one combinational sub-module, tlb_match (entries + VPN2 + ASID in, hit + index out), instantiated three times: instruction, data, probe.

Verification
REQ-031 SHALL test reset then translation: i_req, i_vaddr=0x00400000 -> next cycle i_valid=1, i_miss=1.
REQ-032 SHALL test write then translate:
- write index 3: VPN2=0x00200, ASID=0x05, G=0, PFN0=0x01234, V0=1, D0=0, C0=3.
- asid=0x05, d_req, d_vaddr=0x00400abc, d_store=1 -> d_paddr=0x01234abc, d_modified=1, d_cached=1.
REQ-033 SHALL test ASID mismatch and global: same entry with asid=0x06 -> miss; rewrite entry with G=1 -> hit with PFN0.
REQ-034 SHALL test the unmapped path: i_vaddr=0xA0001000 -> i_paddr=0x00001000, i_cached=0, no miss; 0x80001000 -> same paddr, i_cached=1.
REQ-035 SHALL test probe and read: p_entryhi=0x00400005 -> p_result=0x00000003; unmatched -> 0x80000000; r_index=3 -> r_config equals the written entry.
REQ-036 SHALL test collision: write index 7 and d_req to its address in the same cycle -> miss; repeat one cycle later -> hit.
